mem_data_lsu: RTL and testbench
===============================

MEM_DATA_LSU -- requirements
Module: mem_data_lsu

Interface
REQ-001 Parameter XLEN, default 32: data width in bits; legal values 32 or 64.
REQ-002 Parameter TAM, default 16: depth in XLEN-bit words; must be ≥2.
REQ-003 Parameter ADDRESSLEN, default 32: byte-address width.
REQ-004 Port clk  in  1  single clock; all state changes on posedge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port req_valid  in  1  request present.
REQ-007 Port req_ready  out  1  block can accept a request this cycle.
REQ-008 Port req_we  in  1  1=store, 0=load.
REQ-009 Port req_funct3  in  3  RISC-V size/sign code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-010 Port req_addr  in  ADDRESSLEN  byte address.
REQ-011 Port req_wdata  in  XLEN  store data, right-aligned.
REQ-012 Port rsp_valid  out  1  one-cycle response pulse.
REQ-013 Port rsp_rdata  out  XLEN  load result, extended per funct3.
REQ-014 Port rsp_err  out  1  request rejected (misaligned, out of range, illegal funct3).
REQ-015 Port init_done  out  1  memory clear complete.

Function
REQ-016 FSM states: INIT, IDLE. reset → INIT with clear counter 0.
REQ-017 INIT writes zero to word[counter] each cycle, counter+1; after word TAM-1 → IDLE; INIT lasts exactly TAM cycles.
REQ-018 req_ready = 1 only in IDLE; init_done = 1 only in IDLE.
REQ-019 Handshake: request accepted on posedge where req_valid && req_ready; req_* sampled only then.
REQ-020 Every accepted request yields exactly one rsp_valid pulse on the next posedge; no back-pressure on responses; one request accepted per cycle maximum (throughput 1/cycle).
REQ-021 Word index = req_addr[ADDRESSLEN-1:log2(XLEN/8)]; byte offset = remaining low bits.
REQ-022 Error when: offset not a multiple of access size; word index ≥ TAM; funct3 = 111; funct3 ∈ {011,110} with XLEN=32; funct3 ∈ {100,101,110} with req_we=1.
REQ-023 Erroneous request: no memory update, rsp_err=1, rsp_rdata=0.
REQ-024 Store: only byte lanes covered by size/offset are written, from low bytes of req_wdata; other lanes unchanged; write visible at the response edge.
REQ-025 Load: selected bytes shifted to bit 0; B/H/W sign-extended, BU/HU/WU zero-extended, D full width; rsp_rdata registered.
REQ-026 Store response: rsp_err=0, rsp_rdata=0.
REQ-027 Load accepted the cycle after a store to the same word returns post-store data (no stale read).
REQ-028 rsp_valid, rsp_err, rsp_rdata = 0 in any cycle without a response.

Reset
REQ-029 reset (sampled at posedge) forces state INIT, counter 0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0, init_done=0.
REQ-030 reset mid-operation discards any pending response; no rsp_valid pulse for a request accepted in the reset cycle; memory re-cleared in full.
REQ-031 reset held high: INIT does not advance, counter held 0.

Structure
REQ-032 Shared package holds funct3 encodings (localparams), FSM state enum, and helper function for access-size bytes.
REQ-033 One sub-module, mem_data_lane_align: combinational byte-lane mask/shift/extend for load and store; storage array and FSM stay in mem_data_lsu.

Verification
REQ-034 Assert reset 1 cycle, release -> req_ready=0 for exactly 16 cycles, then 1; load W at 0x3C returns 0x00000000.
REQ-035 SW 0x80FF_7F01 at 0x08, then LB 0x08 → 0x00000001, LB 0x0B → 0xFFFFFF80, LBU 0x0B → 0x00000080, LH 0x0A → 0xFFFF80FF, LHU 0x0A → 0x000080FF.
REQ-036 After REQ-035, SB 0xAA at 0x09 then LW 0x08 back-to-back → 0x80FFAA01 on next rsp_valid; rsp_err=0 throughout.
REQ-037 LH 0x05, SW 0x0A, LW 0x40 (TAM=16), funct3=111 → each rsp_err=1, rsp_rdata=0; subsequent LW 0x04 shows word unchanged.
REQ-038 Accept SW 0x1234_5678 at 0x10 with reset asserted same cycle → no rsp_valid, 16-cycle INIT, LW 0x10 → 0x00000000.
REQ-039 XLEN=64: SD 0x0123_4567_89AB_CDEF at 0x08, LW 0x0C → 0x0000000001234567, LWU 0x08 → 0x0000000089ABCDEF, LD 0x08 returns full value.

Source files
------------

// File: rtl/mem_data_lsu_pkg.sv
// Shared definitions for the load/store data memory: funct3 codes, FSM states
// and the access-size helper.
package mem_data_lsu_pkg;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_BAD = 3'b111;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    // Low two funct3 bits encode log2 of the access size in bytes.
    function automatic logic [3:0] access_bytes(input logic [2:0] f3);
        return 4'd1 << f3[1:0];
    endfunction

endpackage

// File: rtl/mem_data_lsu_if.sv
// Request/response bus between a core-side master and the data memory LSU.
interface mem_data_lsu_if #(
    parameter int XLEN       = 32,
    parameter int ADDRESSLEN = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDRESSLEN-1:0] req_addr;
    logic [XLEN-1:0]       req_wdata;
    logic                  rsp_valid;
    logic [XLEN-1:0]       rsp_rdata;
    logic                  rsp_err;
    logic                  init_done;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );
endinterface

// File: rtl/mem_data_lane_align.sv
// Combinational byte-lane logic: store mask/shift, load shift/extend and
// alignment check for one XLEN-wide word.
module mem_data_lane_align
    import mem_data_lsu_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int NB   = XLEN / 8,
    localparam int OFFW = $clog2(NB)
) (
    input  logic [2:0]      i_funct3,
    input  logic [OFFW-1:0] i_offset,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rword,
    output logic [NB-1:0]   o_wmask,
    output logic [XLEN-1:0] o_wword,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_misaligned
);
    logic [3:0]      w_nbytes;
    logic [NB-1:0]   w_size_mask;
    logic [XLEN-1:0] w_sh;

    assign w_nbytes = access_bytes(i_funct3);

    always_comb begin
        w_size_mask = '0;
        for (int i = 0; i < NB; i++) w_size_mask[i] = (i < int'(w_nbytes));
    end

    // Offset must be a multiple of the access size; sizes wider than the word
    // are rejected elsewhere, so truncating the size mask is harmless.
    assign o_misaligned = |(i_offset & OFFW'(w_nbytes - 4'd1));
    assign o_wmask      = w_size_mask << i_offset;
    assign o_wword      = i_wdata << {i_offset, 3'b000};
    assign w_sh         = i_rword >> {i_offset, 3'b000};

    always_comb begin
        o_rdata = '0;
        case (i_funct3)
            F3_B:    o_rdata = XLEN'($signed(w_sh[7:0]));
            F3_H:    o_rdata = XLEN'($signed(w_sh[15:0]));
            F3_W:    o_rdata = XLEN'($signed(w_sh[31:0]));
            F3_D:    o_rdata = w_sh;
            F3_BU:   o_rdata = XLEN'(w_sh[7:0]);
            F3_HU:   o_rdata = XLEN'(w_sh[15:0]);
            F3_WU:   o_rdata = XLEN'(w_sh[31:0]);
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/mem_data_lsu.sv
// Single-cycle data memory with byte-lane stores, sign/zero-extended loads,
// error rejection and a post-reset clearing pass.
module mem_data_lsu
    import mem_data_lsu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int TAM        = 16,
    parameter int ADDRESSLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    mem_data_lsu_if.slave   bus
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int IDXW = ADDRESSLEN - OFFW;
    localparam int MW   = (TAM > 1) ? $clog2(TAM) : 1;

    state_t          r_state;
    logic [MW-1:0]   r_cnt;
    logic [XLEN-1:0] r_mem [TAM];
    logic            r_rsp_valid;
    logic            r_rsp_err;
    logic [XLEN-1:0] r_rsp_rdata;

    logic [IDXW-1:0] w_idx;
    logic [MW-1:0]   w_widx;
    logic [OFFW-1:0] w_offset;
    logic            w_in_range;
    logic            w_bad_f3;
    logic            w_misaligned;
    logic            w_err;
    logic            w_accept;
    logic [XLEN-1:0] w_rword;
    logic [NB-1:0]   w_wmask;
    logic [XLEN-1:0] w_wword;
    logic [XLEN-1:0] w_ldata;

    assign w_idx      = bus.req_addr[ADDRESSLEN-1:OFFW];
    assign w_offset   = bus.req_addr[OFFW-1:0];
    assign w_widx     = w_idx[MW-1:0];
    assign w_in_range = ({1'b0, w_idx} < (IDXW+1)'(TAM));
    assign w_rword    = w_in_range ? r_mem[w_widx] : '0;
    assign w_accept   = bus.req_valid && (r_state == ST_IDLE);

    always_comb begin
        w_bad_f3 = 1'b0;
        case (bus.req_funct3)
            F3_BAD:       w_bad_f3 = 1'b1;
            F3_D:         w_bad_f3 = (XLEN == 32);
            F3_WU:        w_bad_f3 = (XLEN == 32) || bus.req_we;
            F3_BU, F3_HU: w_bad_f3 = bus.req_we;
            default:      w_bad_f3 = 1'b0;
        endcase
    end

    assign w_err = w_bad_f3 || w_misaligned || !w_in_range;

    mem_data_lane_align #(.XLEN(XLEN)) u_align (
        .i_funct3     (bus.req_funct3),
        .i_offset     (w_offset),
        .i_wdata      (bus.req_wdata),
        .i_rword      (w_rword),
        .o_wmask      (w_wmask),
        .o_wword      (w_wword),
        .o_rdata      (w_ldata),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + MW'(1);
                    if (r_cnt == MW'(TAM - 1)) r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= (w_err || bus.req_we) ? '0 : w_ldata;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    // Loads read the array combinationally, so a store lands before any later load samples it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == ST_INIT) begin
                r_mem[r_cnt] <= '0;
            end else if (w_accept && bus.req_we && !w_err) begin
                for (int b = 0; b < NB; b++)
                    if (w_wmask[b]) r_mem[w_widx][8*b +: 8] <= w_wword[8*b +: 8];
            end
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.init_done = (r_state == ST_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_mem_data_lsu.sv
// Scoreboard bench for mem_data_lsu: a 32-bit and a 64-bit instance checked
// against a byte-array reference model.
module tb_mem_data_lsu;
    import mem_data_lsu_pkg::*;

    logic clk;
    logic reset;

    mem_data_lsu_if #(.XLEN(32), .ADDRESSLEN(32)) b0 ();
    mem_data_lsu_if #(.XLEN(64), .ADDRESSLEN(32)) b1 ();

    mem_data_lsu #(.XLEN(32), .TAM(16), .ADDRESSLEN(32)) u0 (.clk(clk), .reset(reset), .bus(b0));
    mem_data_lsu #(.XLEN(64), .TAM(16), .ADDRESSLEN(32)) u1 (.clk(clk), .reset(reset), .bus(b1));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [64:0] q0[$];
    logic [64:0] q1[$];
    bit [7:0] m [2][128];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endfunction

    // Reference: memory as little-endian bytes, result assembled per access rules.
    function automatic void model(input int d, input bit we, input bit [2:0] f3,
                                  input bit [31:0] addr, input bit [63:0] wd,
                                  output bit err, output bit [63:0] rd);
        int nb = (d == 0) ? 4 : 8;
        int sz = 1 << f3[1:0];
        rd  = '0;
        err = (f3 == 3'd7) || (nb == 4 && (f3 == 3'd3 || f3 == 3'd6)) ||
              (we && f3 >= 3'd4) || (addr % sz != 0) || (addr / nb >= 16);
        if (err) return;
        if (we) begin
            for (int i = 0; i < sz; i++) m[d][addr + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < sz; i++) rd[8*i +: 8] = m[d][addr + i];
            if (f3 < 3'd4 && sz < nb && rd[8*sz-1])
                for (int i = sz; i < nb; i++) rd[8*i +: 8] = 8'hFF;
        end
    endfunction

    always @(negedge clk) begin
        logic [64:0] e;
        if (b0.rsp_valid) begin
            if (q0.size() == 0) chk("rsp0_unexpected", 64'(b0.rsp_valid), 64'd0);
            else begin
                e = q0.pop_front();
                chk("rsp0_err", 64'(b0.rsp_err), 64'(e[64]));
                chk("rsp0_rdata", 64'(b0.rsp_rdata), 64'(e[31:0]));
            end
        end else chk("idle0_zero", {31'd0, b0.rsp_err, b0.rsp_rdata}, 64'd0);
        if (b1.rsp_valid) begin
            if (q1.size() == 0) chk("rsp1_unexpected", 64'(b1.rsp_valid), 64'd0);
            else begin
                e = q1.pop_front();
                chk("rsp1_err", 64'(b1.rsp_err), 64'(e[64]));
                chk("rsp1_rdata", b1.rsp_rdata, e[63:0]);
            end
        end else chk("idle1_zero", b1.rsp_rdata | 64'(b1.rsp_err), 64'd0);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int d, bit v, bit we, bit [2:0] f3, bit [31:0] a, bit [63:0] wd);
        if (d == 0) begin
            b0.req_valid = v; b0.req_we = we; b0.req_funct3 = f3;
            b0.req_addr = a; b0.req_wdata = wd[31:0];
        end else begin
            b1.req_valid = v; b1.req_we = we; b1.req_funct3 = f3;
            b1.req_addr = a; b1.req_wdata = wd;
        end
    endtask

    function automatic logic rdy(int d);
        return (d == 0) ? b0.req_ready : b1.req_ready;
    endfunction

    task automatic issue(int d, bit we, bit [2:0] f3, bit [31:0] a, bit [63:0] wd,
                         bit use_exp = 0, bit e_err = 0, bit [63:0] e_data = 0);
        bit err;
        bit [63:0] rd;
        int t = 0;
        while (!rdy(d) && t < 50) begin cyc(); t++; end
        chk("ready_wait", 64'(rdy(d)), 64'd1);
        model(d, we, f3, a, wd, err, rd);
        if (use_exp) begin err = e_err; rd = e_data; end
        drive(d, 1'b1, we, f3, a, wd);
        if (d == 0) q0.push_back({err, rd}); else q1.push_back({err, rd});
        cyc();
        drive(d, 1'b0, 1'b0, 3'd0, 32'd0, 64'd0);
    endtask

    // Hold reset for 'hold' edges, then count cycles until the block is ready.
    task automatic do_reset(int hold);
        int n = 0;
        reset = 1'b1;
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 64'd0);
            drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 64'd0);
            chk("rst_ready0", 64'(b0.req_ready), 64'd0);
            chk("rst_done0", 64'(b0.init_done), 64'd0);
            chk("rst_ready1", 64'(b1.req_ready), 64'd0);
        end
        reset = 1'b0;
        while (!b0.req_ready && n < 100) begin n++; @(negedge clk); end
        chk("init_cycles", 64'(n), 64'd16);
        chk("init_done0", 64'(b0.init_done), 64'd1);
        chk("init_done1", 64'(b1.init_done), 64'd1);
        for (int d = 0; d < 2; d++) for (int i = 0; i < 128; i++) m[d][i] = 8'h00;
        cyc();
    endtask

    task automatic rand_req(int d);
        int nb = (d == 0) ? 4 : 8;
        bit we = 1'($urandom_range(0, 1));
        bit [2:0] f3 = 3'($urandom_range(0, 7));
        int sz = 1 << f3[1:0];
        bit [31:0] a;
        if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 16 * nb + 7);
        else a = $urandom_range(0, 16 * nb / sz) * sz;
        issue(d, we, f3, a, {$urandom, $urandom});
        if ($urandom_range(0, 3) == 0) cyc();
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 64'd0);
        do_reset(1);

        issue(0, 0, F3_W, 32'h3C, 0, 1, 0, 64'h0);
        issue(0, 1, F3_W, 32'h08, 64'h80FF_7F01, 1, 0, 64'h0);
        issue(0, 0, F3_B,  32'h08, 0, 1, 0, 64'h0000_0001);
        issue(0, 0, F3_B,  32'h0B, 0, 1, 0, 64'hFFFF_FF80);
        issue(0, 0, F3_BU, 32'h0B, 0, 1, 0, 64'h0000_0080);
        issue(0, 0, F3_H,  32'h0A, 0, 1, 0, 64'hFFFF_80FF);
        issue(0, 0, F3_HU, 32'h0A, 0, 1, 0, 64'h0000_80FF);
        issue(0, 1, F3_B,  32'h09, 64'hAA, 1, 0, 64'h0);
        issue(0, 0, F3_W,  32'h08, 0, 1, 0, 64'h80FF_AA01);

        issue(0, 1, F3_W,  32'h04, 64'hDEAD_BEEF, 1, 0, 64'h0);
        issue(0, 0, F3_H,  32'h05, 0, 1, 1, 64'h0);
        issue(0, 1, F3_W,  32'h0A, 64'h1111_1111, 1, 1, 64'h0);
        issue(0, 0, F3_W,  32'h40, 0, 1, 1, 64'h0);
        issue(0, 0, F3_BAD, 32'h00, 0, 1, 1, 64'h0);
        issue(0, 1, F3_BU, 32'h04, 64'h22, 1, 1, 64'h0);
        issue(0, 0, F3_D,  32'h08, 0, 1, 1, 64'h0);
        issue(0, 0, F3_W,  32'h04, 0, 1, 0, 64'hDEAD_BEEF);
        issue(0, 0, F3_W,  32'h08, 0, 1, 0, 64'h80FF_AA01);

        issue(1, 1, F3_D,  32'h08, 64'h0123_4567_89AB_CDEF, 1, 0, 64'h0);
        issue(1, 0, F3_W,  32'h0C, 0, 1, 0, 64'h0000_0000_0123_4567);
        issue(1, 0, F3_WU, 32'h08, 0, 1, 0, 64'h0000_0000_89AB_CDEF);
        issue(1, 0, F3_D,  32'h08, 0, 1, 0, 64'h0123_4567_89AB_CDEF);
        issue(1, 0, F3_W,  32'h08, 0, 1, 0, 64'hFFFF_FFFF_89AB_CDEF);

        issue(0, 1, F3_W,  32'h10, 64'h0000_55AA, 1, 0, 64'h0);
        drive(0, 1'b1, 1'b1, F3_W, 32'h10, 64'h1234_5678);
        do_reset(3);
        issue(0, 0, F3_W,  32'h10, 0, 1, 0, 64'h0);
        issue(1, 0, F3_D,  32'h08, 0, 1, 0, 64'h0);

        for (int k = 0; k < 300; k++) rand_req(0);
        for (int k = 0; k < 200; k++) rand_req(1);

        repeat (3) cyc();
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
